// File: rtl/filter_frame_sched_if.sv
// rtl/filter_frame_sched_if.sv - channel FIFO, engine FIFO and status signals of filter_frame_sched
interface filter_frame_sched_if #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8
);
  logic                  ch0_rd_en;
  logic [DWIDTH_IN-1:0]  ch0_dout;
  logic                  ch0_empty;
  logic                  ch1_rd_en;
  logic [DWIDTH_IN-1:0]  ch1_dout;
  logic                  ch1_empty;
  logic                  ch0_wr_en;
  logic [DWIDTH_OUT-1:0] ch0_din;
  logic                  ch0_full;
  logic                  ch1_wr_en;
  logic [DWIDTH_OUT-1:0] ch1_din;
  logic                  ch1_full;
  logic                  eng_rd_en;
  logic [DWIDTH_IN-1:0]  eng_dout;
  logic                  eng_empty;
  logic                  eng_wr_en;
  logic [DWIDTH_OUT-1:0] eng_din;
  logic                  eng_full;
  logic                  busy;
  logic                  active_ch;
  logic                  frame_done;
  logic                  err;

  modport master (
    output ch0_rd_en, input ch0_dout, input ch0_empty,
    output ch1_rd_en, input ch1_dout, input ch1_empty,
    output ch0_wr_en, output ch0_din, input ch0_full,
    output ch1_wr_en, output ch1_din, input ch1_full,
    input eng_rd_en, output eng_dout, output eng_empty,
    input eng_wr_en, input eng_din, output eng_full,
    output busy, output active_ch, output frame_done, output err
  );

  modport slave (
    input ch0_rd_en, output ch0_dout, output ch0_empty,
    input ch1_rd_en, output ch1_dout, output ch1_empty,
    input ch0_wr_en, input ch0_din, output ch0_full,
    input ch1_wr_en, input ch1_din, output ch1_full,
    output eng_rd_en, input eng_dout, input eng_empty,
    output eng_wr_en, output eng_din, input eng_full,
    input busy, input active_ch, input frame_done, input err
  );
endinterface

// File: rtl/filter_frame_sched.sv
// rtl/filter_frame_sched.sv - frame-granular round-robin sharing of one filter engine between two pixel channels
// Optional drain watchdog enabled by defining FILTER_FRAME_SCHED_TIMEOUT_EN.
module filter_frame_sched #(
  parameter int DWIDTH_IN      = 8,
  parameter int DWIDTH_OUT     = 8,
  parameter int IMG_WIDTH      = 720,
  parameter int IMG_HEIGHT     = 540,
  parameter int CNT_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  filter_frame_sched_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] FRAME_PIXELS = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] LAST_PIXEL   = FRAME_PIXELS - CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_active_ch, w_active_ch_nxt;
  logic                 r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_WIDTH-1:0] r_in_cnt, w_in_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_out_cnt, w_out_cnt_nxt;
  logic                 r_frame_done, w_frame_done_nxt;
  logic                 r_err, w_err_nxt;

  logic                 w_sel_empty, w_sel_full;
  logic [DWIDTH_IN-1:0] w_sel_dout;
  logic                 w_eng_empty, w_eng_full;
  logic                 w_pop, w_wr, w_route_out;

`ifdef FILTER_FRAME_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            w_wdog_fire;
`else
  logic            w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Zero-latency muxing between the granted channel and the engine
  always_comb begin
    w_sel_empty = r_active_ch ? bus.ch1_empty : bus.ch0_empty;
    w_sel_full  = r_active_ch ? bus.ch1_full  : bus.ch0_full;
    w_sel_dout  = r_active_ch ? bus.ch1_dout  : bus.ch0_dout;
    w_eng_empty = (r_state == LOAD) ? w_sel_empty : 1'b1;
    w_eng_full  = (r_state == IDLE) ? 1'b1 : w_sel_full;
    w_pop       = (r_state == LOAD) && bus.eng_rd_en && !w_eng_empty;
    w_route_out = (r_state != IDLE);
    w_wr        = w_route_out && bus.eng_wr_en;
  end

  assign bus.ch0_rd_en  = w_pop && !r_active_ch;
  assign bus.ch1_rd_en  = w_pop && r_active_ch;
  assign bus.eng_dout   = w_sel_dout;
  assign bus.eng_empty  = w_eng_empty;
  assign bus.eng_full   = w_eng_full;
  assign bus.ch0_wr_en  = w_wr && !r_active_ch;
  assign bus.ch1_wr_en  = w_wr && r_active_ch;
  assign bus.ch0_din    = (w_route_out && !r_active_ch) ? bus.eng_din : {DWIDTH_OUT{1'b0}};
  assign bus.ch1_din    = (w_route_out && r_active_ch) ? bus.eng_din : {DWIDTH_OUT{1'b0}};
  assign bus.busy       = (r_state != IDLE);
  assign bus.active_ch  = r_active_ch;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;

  always_comb begin
    w_state_nxt      = r_state;
    w_active_ch_nxt  = r_active_ch;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_in_cnt_nxt     = r_in_cnt;
    w_out_cnt_nxt    = r_out_cnt;
    w_frame_done_nxt = 1'b0;
    w_err_nxt        = r_err;
`ifdef FILTER_FRAME_SCHED_TIMEOUT_EN
    w_wdog_fire = (r_state == DRAIN) && !w_eng_full && !bus.eng_wr_en &&
                  (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    case (r_state)
      IDLE: begin
        if (!bus.ch0_empty || !bus.ch1_empty) begin
          // With only one requester the winner is whichever is non-empty
          w_active_ch_nxt = (!bus.ch0_empty && !bus.ch1_empty) ? r_rr_ptr : bus.ch0_empty;
          w_in_cnt_nxt    = '0;
          w_out_cnt_nxt   = '0;
          w_state_nxt     = LOAD;
        end
      end
      LOAD: begin
        if (w_pop) begin
          w_in_cnt_nxt = r_in_cnt + CNT_WIDTH'(1);
          if (r_in_cnt == LAST_PIXEL) w_state_nxt = DRAIN;
        end
      end
      default: ;
    endcase

    // Frame completion wins over the LOAD->DRAIN move when both land together
    if (w_wr) begin
      w_out_cnt_nxt = r_out_cnt + CNT_WIDTH'(1);
      if (r_out_cnt == LAST_PIXEL) begin
        w_frame_done_nxt = 1'b1;
        w_rr_ptr_nxt     = ~r_active_ch;
        w_state_nxt      = IDLE;
      end
    end

    if (bus.eng_wr_en && ((r_state == IDLE) || w_eng_full)) w_err_nxt = 1'b1;
    if (w_wr && ({1'b0, r_out_cnt} >= ({1'b0, r_in_cnt} + {{CNT_WIDTH{1'b0}}, w_pop})))
      w_err_nxt = 1'b1;

`ifdef FILTER_FRAME_SCHED_TIMEOUT_EN
    if (w_wdog_fire) begin
      w_err_nxt    = 1'b1;
      w_rr_ptr_nxt = ~r_active_ch;
      w_state_nxt  = IDLE;
    end
    w_wdog_nxt = r_wdog;
    if (bus.eng_wr_en || (w_state_nxt != r_state)) w_wdog_nxt = '0;
    else if ((r_state == DRAIN) && !w_eng_full) w_wdog_nxt = r_wdog + WD_W'(1);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_active_ch  <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_ch  <= w_active_ch_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_in_cnt     <= w_in_cnt_nxt;
      r_out_cnt    <= w_out_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

`ifdef FILTER_FRAME_SCHED_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) r_wdog <= '0;
    else       r_wdog <= w_wdog_nxt;
  end
`endif

endmodule

// File: tb/tb_filter_frame_sched.sv
// tb/tb_filter_frame_sched.sv - randomized bench for filter_frame_sched with FIFO and loopback-engine models
module tb_filter_frame_sched;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int FRAME = IMG_W * IMG_H;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  filter_frame_sched_if #(.DWIDTH_IN(8), .DWIDTH_OUT(8)) bus ();

  filter_frame_sched #(
    .DWIDTH_IN(8), .DWIDTH_OUT(8), .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H),
    .CNT_WIDTH(20), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] q_in0[$], q_in1[$], exp0[$], exp1[$], out0[$], out1[$], eng_q[$];
  int grants[$];
  int n_rd0, n_rd1, n_wr0, n_wr1, n_done, cyc, grant_cyc, frame_pops;
  int idle_run, max_gap, drain_busy, drain_nonempty, drain_viol, underflow;
  int rd_pct, wr_pct;
  logic force_full0, prev_busy;

  function automatic int count_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic clear_stats();
    n_rd0 = 0; n_rd1 = 0; n_wr0 = 0; n_wr1 = 0; n_done = 0; grant_cyc = -1;
    frame_pops = 0; idle_run = 0; max_gap = 0; drain_busy = 0; drain_nonempty = 0;
    drain_viol = 0; underflow = 0;
    grants.delete(); out0.delete(); out1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic drive_now();
    bus.ch0_empty = (q_in0.size() == 0);
    bus.ch0_dout  = (q_in0.size() > 0) ? q_in0[0] : 8'h00;
    bus.ch1_empty = (q_in1.size() == 0);
    bus.ch1_dout  = (q_in1.size() > 0) ? q_in1[0] : 8'h00;
    bus.ch0_full  = force_full0;
    bus.ch1_full  = 1'b0;
  endtask

  // Observe at the falling edge, then drive the next cycle's stimulus after the rising edge
  task automatic tick();
    logic [7:0] tmp;
    @(negedge clock);
    cyc++;
    if (bus.busy === 1'b1) begin
      if (!prev_busy) begin
        if (grants.size() > 0 && idle_run > max_gap) max_gap = idle_run;
        grants.push_back(int'(bus.active_ch));
        grant_cyc = cyc;
        frame_pops = 0;
      end
      idle_run = 0;
    end else idle_run++;
    if (bus.busy === 1'b1 && frame_pops == FRAME) begin
      drain_busy++;
      if (bus.active_ch === 1'b0 && q_in0.size() > 0) begin
        drain_nonempty++;
        if (bus.eng_empty !== 1'b1 || bus.ch0_rd_en !== 1'b0) drain_viol++;
      end
    end
    if (bus.ch0_wr_en === 1'b1) begin out0.push_back(bus.ch0_din); n_wr0++; end
    if (bus.ch1_wr_en === 1'b1) begin out1.push_back(bus.ch1_din); n_wr1++; end
    if (bus.eng_wr_en === 1'b1 && eng_q.size() > 0) tmp = eng_q.pop_front();
    if (bus.eng_rd_en === 1'b1 && bus.eng_empty === 1'b0) eng_q.push_back(bus.eng_dout);
    if (bus.ch0_rd_en === 1'b1) begin
      if (q_in0.size() == 0) underflow++; else tmp = q_in0.pop_front();
      n_rd0++; frame_pops++;
    end
    if (bus.ch1_rd_en === 1'b1) begin
      if (q_in1.size() == 0) underflow++; else tmp = q_in1.pop_front();
      n_rd1++; frame_pops++;
    end
    if (bus.frame_done === 1'b1) n_done++;
    prev_busy = (bus.busy === 1'b1);
    @(posedge clock);
    #1;
    drive_now();
    #1;
    bus.eng_rd_en = ($urandom_range(99) < rd_pct);
    if (eng_q.size() > 0 && bus.eng_full === 1'b0 && $urandom_range(99) < wr_pct) begin
      bus.eng_wr_en = 1'b1;
      bus.eng_din   = eng_q[0];
    end else begin
      bus.eng_wr_en = 1'b0;
      bus.eng_din   = 8'($urandom);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    q_in0.delete(); q_in1.delete(); eng_q.delete();
    force_full0 = 1'b0; rd_pct = 0; wr_pct = 0;
    bus.eng_rd_en = 1'b0; bus.eng_wr_en = 1'b0;
    drive_now();
    tick(); tick();
    reset = 1'b0;
    clear_stats();
    prev_busy = 1'b0;
  endtask

  task automatic load(input int ch, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      if (ch == 0) begin q_in0.push_back(v); exp0.push_back(v); end
      else begin q_in1.push_back(v); exp1.push_back(v); end
    end
    drive_now();
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.active_ch !== 1'b0) begin fails++; $display("FAIL reset_active got %b want 0", bus.active_ch); end
    tests++; if ({bus.frame_done, bus.err} !== 2'b00) begin fails++; $display("FAIL reset_done_err got %b want 00", {bus.frame_done, bus.err}); end
    tests++; if ({bus.ch0_rd_en, bus.ch1_rd_en, bus.ch0_wr_en, bus.ch1_wr_en} !== 4'b0000) begin
      fails++; $display("FAIL reset_strobes got %b want 0000", {bus.ch0_rd_en, bus.ch1_rd_en, bus.ch0_wr_en, bus.ch1_wr_en}); end
    tests++; if ({bus.eng_empty, bus.eng_full} !== 2'b11) begin fails++; $display("FAIL reset_eng_flags got %b want 11", {bus.eng_empty, bus.eng_full}); end
  endtask

  task automatic test_single_frame();
    int t0;
    apply_reset();
    rd_pct = 60; wr_pct = 60;
    load(0, FRAME);
    t0 = cyc;
    for (int i = 0; i < 300 && n_done < 1; i++) tick();
    tests++; if (grant_cyc !== t0 + 2) begin fails++; $display("FAIL single_grant_cycle got %0d want %0d", grant_cyc, t0 + 2); end
    tests++; if (grants.size() != 1 || grants[0] != 0) begin fails++; $display("FAIL single_grant_ch got n=%0d want one ch0 grant", grants.size()); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL single_done got %0d want 1", n_done); end
    tests++; if (n_rd0 != FRAME || n_wr0 != FRAME) begin fails++; $display("FAIL single_ch0_counts got rd=%0d wr=%0d want %0d", n_rd0, n_wr0, FRAME); end
    tests++; if (n_rd1 != 0 || n_wr1 != 0) begin fails++; $display("FAIL single_ch1_idle got rd=%0d wr=%0d want 0", n_rd1, n_wr1); end
    tests++; if (count_diff(out0, exp0) != 0) begin fails++; $display("FAIL single_data got %0d diffs want 0", count_diff(out0, exp0)); end
    tick(); tick();
    tests++; if (bus.busy !== 1'b0 || n_done != 1) begin fails++; $display("FAIL single_after got busy=%b done=%0d want 0/1", bus.busy, n_done); end
    tests++; if (bus.err !== 1'b0 || underflow != 0) begin fails++; $display("FAIL single_err got err=%b uf=%0d want 0", bus.err, underflow); end
  endtask

  task automatic test_round_robin();
    int rem0, rem1, rr, w, bad;
    apply_reset();
    rd_pct = 70; wr_pct = 70;
    load(0, 3 * FRAME);
    load(1, 3 * FRAME);
    for (int i = 0; i < 2000 && n_done < 6; i++) tick();
    tests++; if (n_done != 6 || grants.size() != 6) begin fails++; $display("FAIL rr_frames got done=%0d grants=%0d want 6", n_done, grants.size()); end
    rem0 = 3; rem1 = 3; rr = 0; bad = 0;
    for (int k = 0; k < 6; k++) begin
      w = (rem0 > 0 && rem1 > 0) ? rr : (rem0 > 0 ? 0 : 1);
      if (w == 0) rem0--; else rem1--;
      rr = 1 - w;
      if (k >= grants.size() || grants[k] != w) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rr_order got %0d wrong grants want 0", bad); end
    tests++; if (max_gap != 1) begin fails++; $display("FAIL rr_idle_gap got %0d want 1", max_gap); end
    tests++; if (count_diff(out0, exp0) + count_diff(out1, exp1) != 0) begin
      fails++; $display("FAIL rr_data got %0d diffs want 0", count_diff(out0, exp0) + count_diff(out1, exp1)); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL rr_err got %b want 0", bus.err); end
  endtask

  task automatic test_drain_hold();
    apply_reset();
    rd_pct = 100; wr_pct = 25;
    load(0, 20);
    for (int i = 0; i < 500 && n_done < 1; i++) tick();
    tests++; if (n_done != 1 || n_rd0 != FRAME) begin fails++; $display("FAIL drain_first_frame got done=%0d rd=%0d want 1/%0d", n_done, n_rd0, FRAME); end
    tests++; if (drain_nonempty == 0 || drain_viol != 0) begin
      fails++; $display("FAIL drain_hold got cycles=%0d violations=%0d want >0/0", drain_nonempty, drain_viol); end
    for (int i = 0; i < 200 && n_rd0 < 20; i++) tick();
    tests++; if (n_rd0 != 20 || grants.size() != 2) begin fails++; $display("FAIL drain_rest got rd=%0d grants=%0d want 20/2", n_rd0, grants.size()); end
  endtask

  task automatic test_backpressure();
    int w0;
    apply_reset();
    rd_pct = 100; wr_pct = 0;
    load(0, FRAME);
    for (int i = 0; i < 100 && frame_pops < FRAME; i++) tick();
    tick();
    force_full0 = 1'b1; wr_pct = 100;
    drive_now();
    w0 = n_wr0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if ({bus.eng_full, bus.busy, bus.eng_empty} !== 3'b111) begin
        fails++; $display("FAIL bp_hold cycle %0d got full/busy/empty=%b want 111", i, {bus.eng_full, bus.busy, bus.eng_empty}); end
    end
    tests++; if (n_wr0 != w0 || n_done != 0) begin fails++; $display("FAIL bp_no_write got wr=%0d done=%0d want %0d/0", n_wr0, n_done, w0); end
    force_full0 = 1'b0;
    for (int i = 0; i < 100 && n_done < 1; i++) tick();
    tests++; if (n_done != 1 || n_wr0 != FRAME) begin fails++; $display("FAIL bp_complete got done=%0d wr=%0d want 1/%0d", n_done, n_wr0, FRAME); end
    tests++; if (bus.err !== 1'b0 || count_diff(out0, exp0) != 0) begin fails++; $display("FAIL bp_err_data got err=%b diffs=%0d want 0/0", bus.err, count_diff(out0, exp0)); end
  endtask

  // Runs straight after a completed ch0 frame, so the round-robin pointer points at ch1 going in
  task automatic test_reset_mid_frame();
    clear_stats();
    rd_pct = 100; wr_pct = 0;
    load(0, FRAME);
    for (int i = 0; i < 50 && frame_pops < 5; i++) tick();
    bus.eng_rd_en = 1'b0;
    rd_pct = 0;
    tests++; if (dut.r_in_cnt !== 20'd5) begin fails++; $display("FAIL mid_in_cnt got %0d want 5", dut.r_in_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_in0.delete(); eng_q.delete();
    drive_now();
    tests++; if (bus.busy !== 1'b0 || dut.r_in_cnt !== 20'd0) begin fails++; $display("FAIL mid_idle got busy=%b in_cnt=%0d want 0/0", bus.busy, dut.r_in_cnt); end
    tests++; if ({bus.ch0_rd_en, bus.ch1_rd_en, bus.ch0_wr_en, bus.ch1_wr_en, bus.err} !== 5'b0) begin
      fails++; $display("FAIL mid_strobes got %b want 00000", {bus.ch0_rd_en, bus.ch1_rd_en, bus.ch0_wr_en, bus.ch1_wr_en, bus.err}); end
    clear_stats();
    prev_busy = 1'b0;
    load(0, FRAME);
    load(1, FRAME);
    for (int i = 0; i < 10 && grants.size() < 1; i++) tick();
    tests++; if (grants.size() < 1 || grants[0] != 0) begin fails++; $display("FAIL mid_rr_ptr got grants=%0d first=%0d want ch0", grants.size(), (grants.size() > 0) ? grants[0] : -1); end
  endtask

  task automatic test_idle_write_err();
    apply_reset();
    tick();
    bus.eng_wr_en = 1'b1;
    bus.eng_din   = 8'hC3;
    tick();
    tests++; if (n_wr0 + n_wr1 != 0) begin fails++; $display("FAIL idle_wr_passed got %0d writes want 0", n_wr0 + n_wr1); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL idle_wr_err got %b want 1", bus.err); end
    for (int i = 0; i < 5; i++) tick();
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL idle_err_sticky got %b want 1", bus.err); end
    apply_reset();
    tick();
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL idle_err_clear got %b want 0", bus.err); end
  endtask

  task automatic test_drain_stall();
    apply_reset();
    rd_pct = 100; wr_pct = 0;
    load(0, FRAME);
`ifdef FILTER_FRAME_SCHED_TIMEOUT_EN
    for (int i = 0; i < 200 && !(grants.size() > 0 && bus.busy === 1'b0); i++) tick();
    tests++; if (drain_busy != 16) begin fails++; $display("FAIL wdog_cycles got %0d want 16", drain_busy); end
    tests++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || n_done != 0) begin
      fails++; $display("FAIL wdog_end got err=%b busy=%b done=%0d want 1/0/0", bus.err, bus.busy, n_done); end
`else
    for (int i = 0; i < 60; i++) tick();
    tests++; if (bus.busy !== 1'b1 || bus.err !== 1'b0 || n_done != 0 || drain_busy < 40) begin
      fails++; $display("FAIL stall_wait got busy=%b err=%b done=%0d drain=%0d want 1/0/0/>=40", bus.busy, bus.err, n_done, drain_busy); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    force_full0 = 1'b0; prev_busy = 1'b0; cyc = 0;
    bus.eng_rd_en = 1'b0; bus.eng_wr_en = 1'b0; bus.eng_din = 8'h00;
    clear_stats();
    drive_now();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_drain_hold();
    test_backpressure();
    test_reset_mid_frame();
    test_idle_write_err();
    test_drain_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
